tx_bit_sequencer: RTL and testbench
===================================

# tx_bit_sequencer

Bit-level scheduler for the USB TX path. Runs off the system clock, advances only on 12 MHz bit strobes (`clk12`), and sequences the TX shift register and bit counter. It pulls bytes from the packet FSM over a ready/valid handshake, holds the bit count during bit-stuff insertions, and finishes each packet with a fixed SE0/SE0/J end-of-packet.

## Interface
- `DATA_BITS`, 8: bits per byte. `bit_count` width is `$clog2(DATA_BITS)`.
- `EOP_SE0_BITS`, 2: number of SE0 bit times in the EOP.
- `clk`  in  1  system clock; the block's only clock.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `clk12`  in  1  single-cycle bit-time strobe, synchronous to `clk`.
- `start`  in  1  begin packet; sampled in IDLE only.
- `abort`  in  1  synchronous abort; any state goes to IDLE.
- `byte_valid`  in  1  packet FSM has a byte.
- `last_byte`  in  1  qualifies the transferred byte as the final byte.
- `stuff_halt`  in  1  bit stuffer is inserting a bit this bit time.
- `byte_ready`  out  1  combinational; byte accepted when `byte_valid && byte_ready`.
- `load_byte`  out  1  load the shift register (equals the transfer).
- `shift_enable`  out  1  shift one data bit.
- `bit_count`  out  `$clog2(DATA_BITS)`  index of the current data bit.
- `tx_active`  out  1  high from LOAD through EOP_J.
- `eop_se0`, `eop_j`  out  1  line drive requests during EOP.
- `eop_done`  out  1  one-cycle pulse on return to IDLE after EOP.
- `underrun`  out  1  sticky error flag (see Configuration).

## Operation
- States: IDLE, LOAD, SHIFT, EOP_SE0, EOP_J. An SE0 sub-counter runs 0..`EOP_SE0_BITS`-1.
- IDLE → LOAD on `start`. This transition does not need `clk12`.
- LOAD:
  - `byte_ready = clk12`.
  - On a transfer: go to SHIFT, set `bit_count` = 0, capture `last_byte` into `last_flag`.
  - Without a transfer, LOAD waits indefinitely.
- SHIFT, bit strobe (`clk12 && !stuff_halt`):
  - `shift_enable` = 1.
  - If `bit_count` < `DATA_BITS`-1: increment `bit_count`.
- SHIFT, final bit (`bit_count` = `DATA_BITS`-1) on a bit strobe:
  - `byte_ready` = !`last_flag`.
  - Transfer: `load_byte`, wrap `bit_count` to 0, recapture `last_flag`.
  - `last_flag` set: go to EOP_SE0.
  - No `byte_valid`: underrun handling (see Configuration).
- `clk12 && stuff_halt`: no shift, `bit_count` holds, and any byte boundary is deferred to the next non-halted strobe.
- EOP_SE0: `eop_se0` = 1 for `EOP_SE0_BITS` strobes, then go to EOP_J.
- EOP_J: `eop_j` = 1 for one strobe, then go to IDLE with a one-cycle `eop_done` pulse. `stuff_halt` is ignored during EOP.
- `abort` has priority over everything except reset:
  - Next `clk` goes to IDLE and clears `last_flag`.
  - No `eop_done` pulse.
- `start` outside IDLE is ignored.

## Timing
- Reset values: IDLE; all outputs 0, including `bit_count` and `underrun`; `last_flag` = 0.
- Reset mid-packet takes effect immediately. No EOP is sent.
- All state and counter updates occur on `clk` edges where `clk12` is high, except IDLE→LOAD, `abort`, and clearing `eop_done`.
- `byte_ready`, `load_byte`, and `shift_enable` are combinational from state, `clk12`, `stuff_halt`, and `byte_valid`. Each is one `clk` wide.
- Packet of N bytes with no stuffing:
  - First `shift_enable` occurs on the strobe after the LOAD transfer.
  - Exactly 8N `shift_enable` pulses.
  - `eop_done` occurs (8N+3) strobes after the first transfer.
- Each `stuff_halt` strobe adds exactly one strobe of latency.

## Configuration
- `TX_SEQ_UNDERRUN_EN` defined:
  - A missing byte at a non-last boundary sets `underrun`.
  - `underrun` stays set until the next accepted `start`.
  - The FSM goes to EOP_SE0 (packet truncated).
- Not defined:
  - A missing byte ends the packet normally via EOP.
  - `underrun` is tied to 0.

## Structure
- Package `tx_seq_pkg` holds:
  - the state enum `tx_seq_state_t`;
  - localparam defaults `DATA_BITS` = 8 and `EOP_SE0_BITS` = 2.
- Sub-module `tx_seq_bitcnt`: strobe-enabled wrap counter with clear, hold, and terminal-count output. It is used for both `bit_count` and the SE0 sub-counter.

## Test plan
- Reset → IDLE, all outputs 0. `start`, one byte with `last_byte`=1, no stuffing → 8 `shift_enable`, 2 `eop_se0` strobes, 1 `eop_j` strobe, `eop_done` 11 strobes after the transfer.
- 3-byte packet, `byte_valid` held high → `byte_ready`/`load_byte` at strobes 0, 8, 16; 24 shifts; EOP follows.
- `stuff_halt` on the strobe after bit 3 of byte 0 → `bit_count` holds at 4 for one strobe; `eop_done` delayed by exactly 1 strobe.
- Drop `byte_valid` at the byte-1 boundary with macro on → `underrun`=1, EOP sent, `underrun` cleared by the next `start`. With macro off → `underrun`=0, EOP sent.
- `abort` during SHIFT at `bit_count`=5 → IDLE next clk, no `eop_done`. A subsequent packet is correct.
- `n_rst` low during EOP_SE0 → outputs 0 immediately; `start` ignored while `tx_active`.

Source files
------------

// File: rtl/tx_seq_pkg.sv
// Shared types and defaults for the USB TX bit sequencer.
package tx_seq_pkg;

  localparam int DATA_BITS    = 8;
  localparam int EOP_SE0_BITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    EOP_SE0,
    EOP_J
  } tx_seq_state_t;

  // Counter width that stays legal for ranges of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_seq_bitcnt.sv
// Strobe-enabled wrap counter (0..MAX-1) with clear, hold and terminal-count flag.
module tx_seq_bitcnt #(
  parameter int MAX   = 8,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == WIDTH'(MAX - 1));

  // NOTE: non-blocking assignments for registered state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/tx_bit_sequencer.sv
// USB TX bit scheduler: byte handshake, bit counting with stuff holds, SE0/SE0/J end-of-packet.
// Optional: define TX_SEQ_UNDERRUN_EN to flag a missing byte (sticky underrun) and truncate the packet.
module tx_bit_sequencer #(
  parameter int DATA_BITS    = tx_seq_pkg::DATA_BITS,
  parameter int EOP_SE0_BITS = tx_seq_pkg::EOP_SE0_BITS
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         clk12,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         byte_valid,
  input  logic                         last_byte,
  input  logic                         stuff_halt,
  output logic                         byte_ready,
  output logic                         load_byte,
  output logic                         shift_enable,
  output logic [$clog2(DATA_BITS)-1:0] bit_count,
  output logic                         tx_active,
  output logic                         eop_se0,
  output logic                         eop_j,
  output logic                         eop_done,
  output logic                         underrun
);
  import tx_seq_pkg::*;

  localparam int BW = $clog2(DATA_BITS);
  // The EOP counter spans the SE0 bits plus the J bit, so it wraps exactly on return to IDLE.
  localparam int EW = cnt_width(EOP_SE0_BITS + 1);

  tx_seq_state_t state, state_next;
  logic          last_flag;
  logic          bit_strobe;
  logic          bit_tc;
  logic          eop_tc;
  logic [EW-1:0] eop_count;

  assign bit_strobe = clk12 && !stuff_halt && !abort;
  assign load_byte  = byte_ready && byte_valid;
  assign tx_active  = (state != IDLE);
  assign eop_se0    = (state == EOP_SE0);
  assign eop_j      = (state == EOP_J);

  tx_seq_bitcnt #(.MAX(DATA_BITS), .WIDTH(BW)) u_bit_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (abort || state != SHIFT),
    .en    (state == SHIFT && bit_strobe),
    .count (bit_count),
    .tc    (bit_tc)
  );

  tx_seq_bitcnt #(.MAX(EOP_SE0_BITS + 1), .WIDTH(EW)) u_eop_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (abort || !(state == EOP_SE0 || state == EOP_J)),
    .en    (clk12),
    .count (eop_count),
    .tc    (eop_tc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next   = state;
    byte_ready   = 1'b0;
    shift_enable = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_next = LOAD;
        LOAD: begin
          byte_ready = clk12;
          if (clk12 && byte_valid) state_next = SHIFT;
        end
        SHIFT: begin
          if (bit_strobe) begin
            shift_enable = 1'b1;
            if (bit_tc) begin
              byte_ready = !last_flag;
              if (last_flag || !byte_valid) state_next = EOP_SE0;
            end
          end
        end
        EOP_SE0: if (clk12 && eop_count == EW'(EOP_SE0_BITS - 1)) state_next = EOP_J;
        EOP_J:   if (clk12 && eop_tc) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_flag <= 1'b0;
      eop_done  <= 1'b0;
    end else begin
      eop_done <= !abort && state == EOP_J && clk12 && eop_tc;
      if (abort)          last_flag <= 1'b0;
      else if (load_byte) last_flag <= last_byte;
    end
  end

`ifdef TX_SEQ_UNDERRUN_EN
  logic byte_missing;
  assign byte_missing = (state == SHIFT) && bit_strobe && bit_tc && !last_flag && !byte_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                underrun <= 1'b0;
    else if (state == IDLE && start && !abort) underrun <= 1'b0;
    else if (byte_missing)                     underrun <= 1'b1;
  end
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_tx_bit_sequencer.sv
// Self-checking bench for tx_bit_sequencer: directed packet scenarios with randomized waits and stuffing.
module tb_tx_bit_sequencer;

  logic       clk = 1'b0;
  logic       n_rst, clk12, start, abort, byte_valid, last_byte, stuff_halt;
  logic       byte_ready, load_byte, shift_enable, tx_active;
  logic       eop_se0, eop_j, eop_done, underrun;
  logic [2:0] bit_count;

  int vectors     = 0;
  int miscompares = 0;

`ifdef TX_SEQ_UNDERRUN_EN
  localparam bit UNDERRUN_EN = 1'b1;
`else
  localparam bit UNDERRUN_EN = 1'b0;
`endif

  tx_bit_sequencer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clk12        (clk12),
    .start        (start),
    .abort        (abort),
    .byte_valid   (byte_valid),
    .last_byte    (last_byte),
    .stuff_halt   (stuff_halt),
    .byte_ready   (byte_ready),
    .load_byte    (load_byte),
    .shift_enable (shift_enable),
    .bit_count    (bit_count),
    .tx_active    (tx_active),
    .eop_se0      (eop_se0),
    .eop_j        (eop_j),
    .eop_done     (eop_done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outputs"},
          {23'd0, byte_ready, load_byte, shift_enable, tx_active, eop_se0, eop_j, eop_done, underrun}, 0);
    check({tag, "_bit_count"}, bit_count, 0);
  endtask

  // One packet of n bytes. Strobe indices are counted from the packet start; the model tracks
  // data bits shifted, bytes handed over and EOP bit times, and derives expectations from those.
  task automatic run_packet(input int n, input int halt_pct, input int force_halt_at,
                            input int drop_idx, input int abort_at, input bit rst_in_eop);
    int sent = 0, shifts = 0, halts = 0, strobes = 0, t_first = -1, eop_ph = 0, exp_bytes;
    bit data_done = 0, last_sent = 0, exp_underrun = 0, forced = 0, done = 0;
    bit halt, want, valid, chk_bc;
    bit e_ready, e_load, e_shift, e_se0, e_j;
    int e_bc;

    exp_bytes = (drop_idx >= 1 && drop_idx < n) ? drop_idx : n;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("tx_active_after_start", tx_active, 1);
    check("underrun_after_start", underrun, 0);

    while (!done) begin
      if (strobes > 40 * n + 60) begin
        check("strobe_budget_eop_done", done, 1);
        return;
      end

      if (abort_at >= 0 && t_first >= 0 && !data_done && shifts == abort_at) begin
        check("bit_count_before_abort", bit_count, abort_at % 8);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("tx_active_after_abort", tx_active, 0);
        repeat (4) begin
          cycle();
          clk12 = 1'b1; byte_valid = 1'b1;
          @(negedge clk);
          check("byte_ready_after_abort", byte_ready, 0);
          check("shift_after_abort", shift_enable, 0);
          cycle();
          clk12 = 1'b0; byte_valid = 1'b0;
          check("no_eop_done_after_abort", eop_done, 0);
        end
        return;
      end

      if (rst_in_eop && data_done && eop_ph == 0) begin
        check("eop_se0_before_reset", eop_se0, 1);
        n_rst = 1'b0;
        #1;
        check_all_zero("reset_in_eop");
        cycle();
        n_rst = 1'b1;
        cycle();
        return;
      end

      start = 1'($urandom_range(1));
      cycle();
      start = 1'($urandom_range(1));
      cycle();

      clk12 = 1'b1; stuff_halt = 1'b0; byte_valid = 1'b0; last_byte = 1'b0;
      e_ready = 0; e_load = 0; e_shift = 0; e_se0 = 0; e_j = 0; e_bc = 0; chk_bc = 0;

      if (t_first < 0) begin
        valid      = ($urandom_range(3) != 0);
        byte_valid = valid;
        last_byte  = (n == 1);
        e_ready    = 1;
        e_load     = valid;
        if (valid) begin
          t_first   = strobes;
          sent      = 1;
          last_sent = (n == 1);
        end
      end else if (!data_done) begin
        halt = ($urandom_range(99) < halt_pct);
        if (!forced && force_halt_at == shifts) begin
          halt   = 1;
          forced = 1;
        end
        stuff_halt = halt;
        chk_bc     = 1;
        e_bc       = shifts % 8;
        if (halt) begin
          halts++;
          byte_valid = 1'($urandom_range(1));
        end else begin
          e_shift = 1;
          if (shifts % 8 == 7) begin
            want       = !last_sent;
            valid      = want && (sent != drop_idx);
            byte_valid = want ? valid : 1'($urandom_range(1));
            last_byte  = (sent == n - 1);
            e_ready    = want;
            e_load     = want && valid;
            if (e_load) begin
              sent++;
              last_sent = last_byte;
            end else begin
              data_done = 1;
              if (want) exp_underrun = UNDERRUN_EN;
            end
          end else begin
            byte_valid = 1'($urandom_range(1));
          end
          shifts++;
        end
      end else begin
        stuff_halt = 1'($urandom_range(1));
        e_se0 = (eop_ph < 2);
        e_j   = (eop_ph == 2);
        eop_ph++;
      end

      @(negedge clk);
      check("byte_ready", byte_ready, e_ready);
      check("load_byte", load_byte, e_load);
      check("shift_enable", shift_enable, e_shift);
      if (chk_bc) check("bit_count", bit_count, e_bc);
      check("eop_se0", eop_se0, e_se0);
      check("eop_j", eop_j, e_j);
      check("tx_active", tx_active, 1);

      cycle();
      clk12 = 1'b0; stuff_halt = 1'b0; byte_valid = 1'b0; last_byte = 1'b0; start = 1'b0;
      strobes++;
      check("eop_done", eop_done, eop_ph == 3);

      if (eop_ph == 3) begin
        done = 1;
        check("eop_latency", strobes - 1 - t_first, 8 * sent + 3 + halts);
        check("bytes_sent", sent, exp_bytes);
        check("shift_count", shifts, 8 * exp_bytes);
        check("underrun_at_eop", underrun, exp_underrun);
        cycle();
        check("eop_done_width", eop_done, 0);
        check("idle_after_eop", tx_active, 0);
      end
    end
  endtask

  initial begin
    n_rst = 1'b0; clk12 = 1'b0; start = 1'b0; abort = 1'b0;
    byte_valid = 1'b0; last_byte = 1'b0; stuff_halt = 1'b0;
    #12;
    check_all_zero("reset");
    cycle();
    n_rst = 1'b1;
    cycle();
    check_all_zero("idle_after_reset");

    run_packet(1, 0, -1, -1, -1, 1'b0);   // single byte, no stuffing
    run_packet(3, 0, -1, -1, -1, 1'b0);   // three bytes back to back
    run_packet(2, 0, 4, -1, -1, 1'b0);    // one stuff hold at bit_count 4
    run_packet(3, 0, -1, 1, -1, 1'b0);    // byte missing at the byte-1 boundary
    run_packet(1, 0, -1, -1, -1, 1'b0);   // clean packet clears underrun on start
    run_packet(2, 0, -1, -1, 5, 1'b0);    // abort at bit_count 5
    run_packet(2, 10, -1, -1, -1, 1'b0);  // packet after abort, light stuffing
    run_packet(2, 0, -1, -1, -1, 1'b1);   // reset during EOP SE0
    run_packet(1, 0, -1, -1, -1, 1'b0);   // packet after reset

    repeat (6)
      run_packet(int'($urandom_range(4, 1)), 15, -1,
                 ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
